// File: rtl/lut_builder.sv
// lut_builder: builds the 16 subset-sum LUT entries of a signed activation group, one entry per cycle.
// Optional LUT_DBUF_EN: build into a shadow bank while the output bank stays held.
module lut_builder #(
  parameter int unsigned ACT_W = 8,
  parameter int unsigned LUT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             act_valid_i,
  output logic             act_ready_o,
  input  logic [ACT_W-1:0] act_0_i,
  input  logic [ACT_W-1:0] act_1_i,
  input  logic [ACT_W-1:0] act_2_i,
  input  logic [ACT_W-1:0] act_3_i,
  output logic [LUT_W-1:0] lut_0_o,
  output logic [LUT_W-1:0] lut_1_o,
  output logic [LUT_W-1:0] lut_2_o,
  output logic [LUT_W-1:0] lut_3_o,
  output logic [LUT_W-1:0] lut_4_o,
  output logic [LUT_W-1:0] lut_5_o,
  output logic [LUT_W-1:0] lut_6_o,
  output logic [LUT_W-1:0] lut_7_o,
  output logic [LUT_W-1:0] lut_8_o,
  output logic [LUT_W-1:0] lut_9_o,
  output logic [LUT_W-1:0] lut_10_o,
  output logic [LUT_W-1:0] lut_11_o,
  output logic [LUT_W-1:0] lut_12_o,
  output logic [LUT_W-1:0] lut_13_o,
  output logic [LUT_W-1:0] lut_14_o,
  output logic [LUT_W-1:0] lut_15_o,
  output logic             lut_valid_o,
  input  logic             lut_ready_i,
  output logic             busy_o
);

  localparam int unsigned N_ACT = 4;
  localparam int unsigned N_ENT = 16;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned EXT_W = LUT_W - ACT_W;
  localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(N_ENT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUILD = 2'd1,
    S_DONE  = 2'd2,
    S_WAIT  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACT_W-1:0] act_q [N_ACT];
  logic [ACT_W-1:0] act_d [N_ACT];
  logic [LUT_W-1:0] lut_q [N_ENT];
  logic [LUT_W-1:0] lut_d [N_ENT];
  logic             lut_valid_q, lut_valid_d;
  logic             act_ready_q, act_ready_d;
  logic             busy_q, busy_d;

  logic             accept_c;
  logic [CNT_W-1:0] src_idx_c;
  logic [1:0]       bit_idx_c;
  logic [ACT_W-1:0] act_sel_c;
  logic [LUT_W-1:0] base_c;
  logic [LUT_W-1:0] sum_c;

`ifdef LUT_DBUF_EN
  logic [LUT_W-1:0] sh_q [N_ENT];
  logic [LUT_W-1:0] sh_d [N_ENT];
  logic             out_free_c;
`endif

  assign accept_c  = act_valid_i & act_ready_q;
  assign src_idx_c = cnt_q & (cnt_q - CNT_W'(1));

  // Index of the lowest set bit of cnt selects the activation added to entry[k & (k-1)]
  always_comb begin
    bit_idx_c = 2'd3;
    if (cnt_q[0]) begin
      bit_idx_c = 2'd0;
    end else if (cnt_q[1]) begin
      bit_idx_c = 2'd1;
    end else if (cnt_q[2]) begin
      bit_idx_c = 2'd2;
    end
  end

  assign act_sel_c = act_q[bit_idx_c];
`ifdef LUT_DBUF_EN
  assign base_c = sh_q[src_idx_c];
`else
  assign base_c = lut_q[src_idx_c];
`endif
  assign sum_c = base_c + {{EXT_W{act_sel_c[ACT_W-1]}}, act_sel_c};

`ifdef LUT_DBUF_EN
  assign out_free_c = ~lut_valid_q | lut_ready_i;

  // Engine FSM with shadow bank; the output bank loads on build completion or on release
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    act_d       = act_q;
    lut_d       = lut_q;
    sh_d        = sh_q;
    lut_valid_d = lut_valid_q & ~lut_ready_i;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          state_d  = S_BUILD;
          cnt_d    = CNT_FIRST;
          act_d[0] = act_0_i;
          act_d[1] = act_1_i;
          act_d[2] = act_2_i;
          act_d[3] = act_3_i;
          sh_d[0]  = '0;
        end
      end
      S_BUILD: begin
        sh_d[cnt_q] = sum_c;
        cnt_d       = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (out_free_c) begin
            lut_d          = sh_q;
            lut_d[N_ENT-1] = sum_c;
            lut_valid_d    = 1'b1;
            state_d        = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (lut_ready_i) begin
          lut_d       = sh_q;
          lut_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    act_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d == S_BUILD) || (state_d == S_WAIT);
  end
`else
  // Engine FSM building directly into the output registers
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    lut_d   = lut_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          state_d  = S_BUILD;
          cnt_d    = CNT_FIRST;
          act_d[0] = act_0_i;
          act_d[1] = act_1_i;
          act_d[2] = act_2_i;
          act_d[3] = act_3_i;
          lut_d[0] = '0;
        end
      end
      S_BUILD: begin
        lut_d[cnt_q] = sum_c;
        cnt_d        = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (lut_valid_q && lut_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    lut_valid_d = (state_d == S_DONE);
    act_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d == S_BUILD);
  end
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lut_valid_q <= 1'b0;
      act_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int unsigned i = 0; i < N_ACT; i++) begin
        act_q[i] <= '0;
      end
      for (int unsigned i = 0; i < N_ENT; i++) begin
        lut_q[i] <= '0;
`ifdef LUT_DBUF_EN
        sh_q[i]  <= '0;
`endif
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lut_valid_q <= lut_valid_d;
      act_ready_q <= act_ready_d;
      busy_q      <= busy_d;
      act_q       <= act_d;
      lut_q       <= lut_d;
`ifdef LUT_DBUF_EN
      sh_q        <= sh_d;
`endif
    end
  end

  assign act_ready_o = act_ready_q;
  assign lut_valid_o = lut_valid_q;
  assign busy_o      = busy_q;

  assign lut_0_o  = lut_q[0];
  assign lut_1_o  = lut_q[1];
  assign lut_2_o  = lut_q[2];
  assign lut_3_o  = lut_q[3];
  assign lut_4_o  = lut_q[4];
  assign lut_5_o  = lut_q[5];
  assign lut_6_o  = lut_q[6];
  assign lut_7_o  = lut_q[7];
  assign lut_8_o  = lut_q[8];
  assign lut_9_o  = lut_q[9];
  assign lut_10_o = lut_q[10];
  assign lut_11_o = lut_q[11];
  assign lut_12_o = lut_q[12];
  assign lut_13_o = lut_q[13];
  assign lut_14_o = lut_q[14];
  assign lut_15_o = lut_q[15];

endmodule

// File: tb/tb_lut_builder.sv
// Testbench for lut_builder: random activation groups checked against a subset-sum model.
module tb_lut_builder;

  localparam int unsigned ACT_W = 8;
  localparam int unsigned LUT_W = 16;
`ifdef LUT_DBUF_EN
  localparam int PERIOD = 16;
`else
  localparam int PERIOD = 17;
`endif

  logic             clk_i = 1'b0;
  logic             rst_n_i = 1'b0;
  logic             act_valid_i = 1'b0;
  logic             lut_ready_i = 1'b0;
  logic [ACT_W-1:0] act_i [4];
  logic [LUT_W-1:0] lut_o [16];
  logic             act_ready_o, lut_valid_o, busy_o;

  logic [LUT_W-1:0] exp_lut [16];
  int total = 0;
  int bad = 0;

  always #5 clk_i = ~clk_i;

  lut_builder #(.ACT_W(ACT_W), .LUT_W(LUT_W)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .act_valid_i(act_valid_i), .act_ready_o(act_ready_o),
    .act_0_i(act_i[0]), .act_1_i(act_i[1]), .act_2_i(act_i[2]), .act_3_i(act_i[3]),
    .lut_0_o(lut_o[0]), .lut_1_o(lut_o[1]), .lut_2_o(lut_o[2]), .lut_3_o(lut_o[3]),
    .lut_4_o(lut_o[4]), .lut_5_o(lut_o[5]), .lut_6_o(lut_o[6]), .lut_7_o(lut_o[7]),
    .lut_8_o(lut_o[8]), .lut_9_o(lut_o[9]), .lut_10_o(lut_o[10]), .lut_11_o(lut_o[11]),
    .lut_12_o(lut_o[12]), .lut_13_o(lut_o[13]), .lut_14_o(lut_o[14]), .lut_15_o(lut_o[15]),
    .lut_valid_o(lut_valid_o), .lut_ready_i(lut_ready_i), .busy_o(busy_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Reference: entry k is the plain sum of every activation whose bit is set in k
  task automatic compute_exp(input int a0, input int a1, input int a2, input int a3,
                             output logic [LUT_W-1:0] e [16]);
    int a [4];
    int s;
    a = '{a0, a1, a2, a3};
    for (int k = 0; k < 16; k++) begin
      s = 0;
      for (int i = 0; i < 4; i++) if (((k >> i) & 1) == 1) s += a[i];
      e[k] = LUT_W'(s);
    end
  endtask

  function automatic int rnd_act();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  // Present a group and advance through its accept edge; flags an expired wait for act_ready
  task automatic do_accept(input int a0, input int a1, input int a2, input int a3, output bit to);
    int n;
    n = 0;
    act_i[0] = ACT_W'(a0);
    act_i[1] = ACT_W'(a1);
    act_i[2] = ACT_W'(a2);
    act_i[3] = ACT_W'(a3);
    act_valid_i = 1'b1;
    while (act_ready_o !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    to = (n >= 100);
    step();
    act_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    int diffs;
    repeat (3) step();
    diffs = 0;
    for (int k = 0; k < 16; k++) if (lut_o[k] !== '0) diffs++;
    total++;
    if (diffs != 0 || lut_valid_o !== 1'b0 || busy_o !== 1'b0 || act_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: nonzero_entries=%0d valid=%b busy=%b ready=%b, need 0/0/0/0",
               diffs, lut_valid_o, busy_o, act_ready_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    step();
    total++;
    if (act_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: act_ready=%b need 1", act_ready_o);
    end
  endtask

  task automatic test_basic();
    bit to;
    do_accept(1, 2, 4, 8, to);
    compute_exp(1, 2, 4, 8, exp_lut);
    total++;
    if (to) begin bad++; $display("FAIL basic_accept: timed out waiting for act_ready"); end
    total++;
    if (busy_o !== 1'b1 || act_ready_o !== 1'b0 || lut_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL basic_busy: busy=%b ready=%b valid=%b need 1/0/0", busy_o, act_ready_o, lut_valid_o);
    end
    repeat (14) step();
    total++;
    if (lut_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL basic_early_valid: valid=%b after 14 edges, need 0", lut_valid_o);
    end
    step();
    total++;
    if (lut_valid_o !== 1'b1 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL basic_latency: valid=%b busy=%b after 15 edges, need 1/0", lut_valid_o, busy_o);
    end
    for (int k = 0; k < 16; k++) begin
      total++;
      if (lut_o[k] !== exp_lut[k] || lut_o[k] !== LUT_W'(k)) begin
        bad++;
        $display("FAIL basic_lut_%0d: got %0d need %0d", k, lut_o[k], k);
      end
    end
    lut_ready_i = 1'b1;
    step();
    lut_ready_i = 1'b0;
    total++;
    if (act_ready_o !== 1'b1 || lut_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL basic_release: ready=%b valid=%b need 1/0", act_ready_o, lut_valid_o);
    end
  endtask

  task automatic test_neg_extremes();
    bit to;
    do_accept(-128, -128, -128, -128, to);
    compute_exp(-128, -128, -128, -128, exp_lut);
    repeat (15) step();
    total++;
    if (to || lut_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL neg_valid: timeout=%b valid=%b need 0/1", to, lut_valid_o);
    end
    total++;
    if (lut_o[15] !== 16'hFE00 || lut_o[7] !== 16'hFE80 || lut_o[1] !== 16'hFF80 || lut_o[0] !== 16'h0000) begin
      bad++;
      $display("FAIL neg_consts: l15=%h l7=%h l1=%h l0=%h need fe00/fe80/ff80/0000",
               lut_o[15], lut_o[7], lut_o[1], lut_o[0]);
    end
    for (int k = 0; k < 16; k++) begin
      total++;
      if (lut_o[k] !== exp_lut[k]) begin
        bad++;
        $display("FAIL neg_lut_%0d: got %h need %h", k, lut_o[k], exp_lut[k]);
      end
    end
    lut_ready_i = 1'b1;
    step();
    lut_ready_i = 1'b0;
  endtask

  task automatic test_random();
    bit to;
    int a [4];
    int diffs;
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < 4; i++) a[i] = rnd_act();
      do_accept(a[0], a[1], a[2], a[3], to);
      compute_exp(a[0], a[1], a[2], a[3], exp_lut);
      repeat (15) step();
      total++;
      if (to || lut_valid_o !== 1'b1) begin
        bad++;
        $display("FAIL rand_valid_%0d: timeout=%b valid=%b need 0/1", it, to, lut_valid_o);
      end
      for (int k = 0; k < 16; k++) begin
        total++;
        if (lut_o[k] !== exp_lut[k]) begin
          bad++;
          $display("FAIL rand_%0d_lut_%0d: got %h need %h (a=%0d,%0d,%0d,%0d)",
                   it, k, lut_o[k], exp_lut[k], a[0], a[1], a[2], a[3]);
        end
      end
      repeat ($urandom_range(0, 3)) step();
      diffs = 0;
      for (int k = 0; k < 16; k++) if (lut_o[k] !== exp_lut[k]) diffs++;
      total++;
      if (diffs != 0 || lut_valid_o !== 1'b1) begin
        bad++;
        $display("FAIL rand_hold_%0d: changed_entries=%0d valid=%b need 0/1", it, diffs, lut_valid_o);
      end
      lut_ready_i = 1'b1;
      step();
      lut_ready_i = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int a [4];
    int diffs;
    for (int i = 0; i < 4; i++) a[i] = rnd_act();
    do_accept(a[0], a[1], a[2], a[3], to);
    compute_exp(a[0], a[1], a[2], a[3], exp_lut);
    repeat (15) step();
    for (int c = 0; c < 40; c++) begin
      act_valid_i = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) act_i[i] = ACT_W'($urandom);
      step();
      diffs = 0;
      for (int k = 0; k < 16; k++) if (lut_o[k] !== exp_lut[k]) diffs++;
      total++;
      if (diffs != 0 || lut_valid_o !== 1'b1 || act_ready_o !== 1'b0 || busy_o !== 1'b0) begin
        bad++;
        $display("FAIL bp_cycle_%0d: changed_entries=%0d valid=%b ready=%b busy=%b need 0/1/0/0",
                 c, diffs, lut_valid_o, act_ready_o, busy_o);
      end
    end
    act_valid_i = 1'b0;
    lut_ready_i = 1'b1;
    step();
    lut_ready_i = 1'b0;
    total++;
    if (act_ready_o !== 1'b1 || lut_valid_o !== 1'b0 || to) begin
      bad++;
      $display("FAIL bp_release: ready=%b valid=%b timeout=%b need 1/0/0", act_ready_o, lut_valid_o, to);
    end
  endtask

  task automatic test_reset_midbuild();
    bit to;
    int diffs;
    do_accept(rnd_act(), rnd_act(), rnd_act(), rnd_act(), to);
    repeat (7) step();
    rst_n_i = 1'b0;
    #1;
    diffs = 0;
    for (int k = 0; k < 16; k++) if (lut_o[k] !== '0) diffs++;
    total++;
    if (diffs != 0 || lut_valid_o !== 1'b0 || busy_o !== 1'b0 || act_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL midreset_state: nonzero_entries=%0d valid=%b busy=%b ready=%b need 0/0/0/0",
               diffs, lut_valid_o, busy_o, act_ready_o);
    end
    repeat (2) step();
    @(negedge clk_i);
    rst_n_i = 1'b1;
    do_accept(3, -1, 5, 0, to);
    compute_exp(3, -1, 5, 0, exp_lut);
    repeat (15) step();
    total++;
    if (to || lut_valid_o !== 1'b1 || lut_o[15] !== 16'd7 || lut_o[6] !== 16'd4) begin
      bad++;
      $display("FAIL midreset_rebuild: timeout=%b valid=%b l15=%0d l6=%0d need 0/1/7/4",
               to, lut_valid_o, lut_o[15], lut_o[6]);
    end
    for (int k = 0; k < 16; k++) begin
      total++;
      if (lut_o[k] !== exp_lut[k]) begin
        bad++;
        $display("FAIL midreset_lut_%0d: got %h need %h", k, lut_o[k], exp_lut[k]);
      end
    end
    lut_ready_i = 1'b1;
    step();
    lut_ready_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    int a [4];
    int rise [$];
    bit prev;
    for (int i = 0; i < 4; i++) a[i] = rnd_act();
    compute_exp(a[0], a[1], a[2], a[3], exp_lut);
    for (int i = 0; i < 4; i++) act_i[i] = ACT_W'(a[i]);
    act_valid_i = 1'b1;
    lut_ready_i = 1'b1;
    prev = lut_valid_o;
    for (int s = 1; s <= 60; s++) begin
      step();
      if (lut_valid_o === 1'b1 && prev !== 1'b1) begin
        rise.push_back(s);
        for (int k = 0; k < 16; k++) begin
          total++;
          if (lut_o[k] !== exp_lut[k]) begin
            bad++;
            $display("FAIL b2b_step%0d_lut_%0d: got %h need %h", s, k, lut_o[k], exp_lut[k]);
          end
        end
      end
      prev = lut_valid_o;
    end
    act_valid_i = 1'b0;
    total++;
    if (rise.size() < 2) begin
      bad++;
      $display("FAIL b2b_count: valid rises=%0d need >=2", rise.size());
    end else begin
      total++;
      if (rise[0] != 16 || rise[1] - rise[0] != PERIOD) begin
        bad++;
        $display("FAIL b2b_period: first rise at step %0d spacing %0d, need 16 and %0d",
                 rise[0], rise[1] - rise[0], PERIOD);
      end
    end
    repeat (40) step();
    lut_ready_i = 1'b0;
    step();
  endtask

`ifdef LUT_DBUF_EN
  task automatic test_dbuf_overlap();
    logic [LUT_W-1:0] exp2 [16];
    int diffs;
    compute_exp(1, 2, 4, 8, exp_lut);
    compute_exp(10, 20, 40, 80, exp2);
    lut_ready_i = 1'b0;
    act_i[0] = 8'd1; act_i[1] = 8'd2; act_i[2] = 8'd4; act_i[3] = 8'd8;
    act_valid_i = 1'b1;
    step();
    act_i[0] = 8'd10; act_i[1] = 8'd20; act_i[2] = 8'd40; act_i[3] = 8'd80;
    repeat (15) step();
    total++;
    if (lut_valid_o !== 1'b1 || act_ready_o !== 1'b1 || lut_o[15] !== exp_lut[15]) begin
      bad++;
      $display("FAIL dbuf_first: valid=%b ready=%b l15=%0d need 1/1/15", lut_valid_o, act_ready_o, lut_o[15]);
    end
    step();
    act_valid_i = 1'b0;
    diffs = 0;
    for (int c = 0; c < 14; c++) begin
      for (int k = 0; k < 16; k++) if (lut_o[k] !== exp_lut[k]) diffs++;
      if (lut_valid_o !== 1'b1 || busy_o !== 1'b1) diffs++;
      step();
    end
    total++;
    if (diffs != 0) begin
      bad++;
      $display("FAIL dbuf_hold: %0d deviations while second build runs, need 0", diffs);
    end
    lut_ready_i = 1'b1;
    step();
    lut_ready_i = 1'b0;
    total++;
    if (lut_valid_o !== 1'b1 || lut_o[15] !== 16'd150 || busy_o !== 1'b0 || act_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL dbuf_second: valid=%b l15=%0d busy=%b ready=%b need 1/150/0/1",
               lut_valid_o, lut_o[15], busy_o, act_ready_o);
    end
    for (int k = 0; k < 16; k++) begin
      total++;
      if (lut_o[k] !== exp2[k]) begin
        bad++;
        $display("FAIL dbuf_second_lut_%0d: got %h need %h", k, lut_o[k], exp2[k]);
      end
    end
    lut_ready_i = 1'b1;
    step();
    lut_ready_i = 1'b0;
  endtask

  task automatic test_dbuf_wait();
    bit to;
    int a [4];
    int b [4];
    int diffs;
    logic [LUT_W-1:0] exp2 [16];
    for (int i = 0; i < 4; i++) begin a[i] = rnd_act(); b[i] = rnd_act(); end
    compute_exp(a[0], a[1], a[2], a[3], exp_lut);
    compute_exp(b[0], b[1], b[2], b[3], exp2);
    lut_ready_i = 1'b0;
    do_accept(a[0], a[1], a[2], a[3], to);
    repeat (15) step();
    do_accept(b[0], b[1], b[2], b[3], to);
    repeat (15) step();
    diffs = 0;
    for (int c = 0; c < 10; c++) begin
      for (int k = 0; k < 16; k++) if (lut_o[k] !== exp_lut[k]) diffs++;
      if (lut_valid_o !== 1'b1 || busy_o !== 1'b1 || act_ready_o !== 1'b0) diffs++;
      step();
    end
    total++;
    if (diffs != 0 || to) begin
      bad++;
      $display("FAIL dbuf_wait_hold: %0d deviations timeout=%b, need 0/0", diffs, to);
    end
    lut_ready_i = 1'b1;
    step();
    lut_ready_i = 1'b0;
    total++;
    if (lut_valid_o !== 1'b1 || busy_o !== 1'b0 || act_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL dbuf_wait_release: valid=%b busy=%b ready=%b need 1/0/1", lut_valid_o, busy_o, act_ready_o);
    end
    for (int k = 0; k < 16; k++) begin
      total++;
      if (lut_o[k] !== exp2[k]) begin
        bad++;
        $display("FAIL dbuf_wait_lut_%0d: got %h need %h", k, lut_o[k], exp2[k]);
      end
    end
    lut_ready_i = 1'b1;
    step();
    lut_ready_i = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 4; i++) act_i[i] = '0;
    test_reset();
    test_basic();
    test_neg_extremes();
    test_random();
`ifdef LUT_DBUF_EN
    test_dbuf_overlap();
    test_dbuf_wait();
`else
    test_backpressure();
`endif
    test_reset_midbuild();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
